// File: rtl/sync_fifo_ext.sv
// Single-clock FIFO with registered-read or first-word-fall-through output,
// occupancy/threshold flags, high-water tracking and overflow/underflow pulses.
module sync_fifo_ext #(
  parameter int unsigned WIDTH              = 4,
  parameter int unsigned DEPTH              = 16,
  parameter int unsigned FWFT               = 0,
  parameter int unsigned ALMOST_FULL_DEPTH  = 14,
  parameter int unsigned ALMOST_EMPTY_DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     wren,
  input  logic [WIDTH-1:0]         din,
  input  logic                     rden,
  output logic [WIDTH-1:0]         dout,
  output logic                     dout_valid,
  output logic                     full,
  output logic                     empty,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic [$clog2(DEPTH):0]   fifo_counter,
  output logic [$clog2(DEPTH):0]   high_water,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [CW-1:0]    high_water_q, high_water_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             almost_full_q, almost_full_d;
  logic             almost_empty_q, almost_empty_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             dout_valid_q, dout_valid_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;

  logic             rd_acc_c;
  logic             wr_acc_c;
  logic [WIDTH-1:0] head_c;

  // A read needs stored data; a write into a full FIFO is fine only when a read frees a slot.
  always_comb begin
    rd_acc_c = rden && !flush && !empty_q;
    wr_acc_c = wren && !flush && (!full_q || rd_acc_c);
  end

  // Next-state for pointers, occupancy, flags and read data.
  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    dout_d       = dout_q;
    dout_valid_d = 1'b0;
    overflow_d   = 1'b0;
    underflow_d  = 1'b0;

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_acc_c) wr_ptr_d = wr_ptr_q + AW'(1);
      if (rd_acc_c) rd_ptr_d = rd_ptr_q + AW'(1);
      if (wr_acc_c && !rd_acc_c)      count_d = count_q + CW'(1);
      else if (rd_acc_c && !wr_acc_c) count_d = count_q - CW'(1);
      if (rd_acc_c) begin
        dout_d       = mem_q[rd_ptr_q];
        dout_valid_d = 1'b1;
      end
      overflow_d  = wren && !wr_acc_c;
      underflow_d = rden && empty_q;
    end

    full_d         = (count_d == CW'(DEPTH));
    empty_d        = (count_d == '0);
    almost_full_d  = (count_d >= CW'(ALMOST_FULL_DEPTH));
    almost_empty_d = (count_d <= CW'(ALMOST_EMPTY_DEPTH));

    if (flush)                        high_water_d = '0;
    else if (count_d > high_water_q)  high_water_d = count_d;
    else                              high_water_d = high_water_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      high_water_q   <= '0;
      full_q         <= 1'b0;
      empty_q        <= 1'b1;
      almost_full_q  <= 1'b0;
      almost_empty_q <= 1'b1;
      dout_q         <= '0;
      dout_valid_q   <= 1'b0;
      overflow_q     <= 1'b0;
      underflow_q    <= 1'b0;
    end else begin
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      high_water_q   <= high_water_d;
      full_q         <= full_d;
      empty_q        <= empty_d;
      almost_full_q  <= almost_full_d;
      almost_empty_q <= almost_empty_d;
      dout_q         <= dout_d;
      dout_valid_q   <= dout_valid_d;
      overflow_q     <= overflow_d;
      underflow_q    <= underflow_d;
    end
  end

  // Storage carries no reset; only pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (!rst && wr_acc_c) mem_q[wr_ptr_q] <= din;
  end

  // Fall-through head is forced to zero while empty so stale storage never shows.
  always_comb begin
    head_c = empty_q ? '0 : mem_q[rd_ptr_q];
  end

  assign dout         = (FWFT != 0) ? head_c   : dout_q;
  assign dout_valid   = (FWFT != 0) ? !empty_q : dout_valid_q;
  assign full         = full_q;
  assign empty        = empty_q;
  assign almost_full  = almost_full_q;
  assign almost_empty = almost_empty_q;
  assign fifo_counter = count_q;
  assign high_water   = high_water_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

endmodule

// File: tb/tb_sync_fifo_ext.sv
// Directed bench: registered-read and fall-through instances share one stimulus stream.
module tb_sync_fifo_ext;

  logic       clk = 1'b0;
  logic       rst, flush, wren, rden;
  logic [3:0] din;

  logic [3:0] a_dout, b_dout;
  logic       a_dv, a_full, a_empty, a_af, a_ae, a_ovf, a_udf;
  logic       b_dv, b_full, b_empty, b_af, b_ae, b_ovf, b_udf;
  logic [4:0] a_cnt, a_hw, b_cnt, b_hw;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sync_fifo_ext #(.WIDTH(4), .DEPTH(16), .FWFT(0), .ALMOST_FULL_DEPTH(14), .ALMOST_EMPTY_DEPTH(2)) u_reg (
    .clk(clk), .rst(rst), .flush(flush), .wren(wren), .din(din), .rden(rden),
    .dout(a_dout), .dout_valid(a_dv), .full(a_full), .empty(a_empty),
    .almost_full(a_af), .almost_empty(a_ae), .fifo_counter(a_cnt), .high_water(a_hw),
    .overflow(a_ovf), .underflow(a_udf));

  sync_fifo_ext #(.WIDTH(4), .DEPTH(16), .FWFT(1), .ALMOST_FULL_DEPTH(14), .ALMOST_EMPTY_DEPTH(2)) u_fwft (
    .clk(clk), .rst(rst), .flush(flush), .wren(wren), .din(din), .rden(rden),
    .dout(b_dout), .dout_valid(b_dv), .full(b_full), .empty(b_empty),
    .almost_full(b_af), .almost_empty(b_ae), .fifo_counter(b_cnt), .high_water(b_hw),
    .overflow(b_ovf), .underflow(b_udf));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rst = 1'b0; flush = 1'b0; wren = 1'b0; rden = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; wren = 1'b0; rden = 1'b0; din = 4'h0;
    tick(); tick();
    idle();
    checks++; if (a_cnt !== 5'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", a_cnt); end
    checks++; if (a_hw !== 5'd0) begin errors++; $display("FAIL reset_hw got %0d exp 0", a_hw); end
    checks++; if ({a_empty, a_full, a_ae, a_af} !== 4'b1010) begin errors++; $display("FAIL reset_flags got %b exp 1010", {a_empty, a_full, a_ae, a_af}); end
    checks++; if ({a_dv, a_ovf, a_udf} !== 3'b000) begin errors++; $display("FAIL reset_pulses got %b exp 000", {a_dv, a_ovf, a_udf}); end
    checks++; if (a_dout !== 4'h0) begin errors++; $display("FAIL reset_dout got %0h exp 0", a_dout); end
    checks++; if ({b_dv, b_dout} !== 5'h00) begin errors++; $display("FAIL reset_fwft got %0h exp 0", {b_dv, b_dout}); end
  endtask

  task automatic test_fill();
    for (int i = 0; i < 16; i++) begin
      wren = 1'b1; din = 4'(i);
      tick();
      checks++; if (a_cnt !== 5'(i + 1)) begin errors++; $display("FAIL fill_count[%0d] got %0d exp %0d", i, a_cnt, i + 1); end
      checks++; if (a_af !== (i + 1 >= 14)) begin errors++; $display("FAIL fill_af[%0d] got %b exp %b", i, a_af, (i + 1 >= 14)); end
      checks++; if (a_full !== (i == 15)) begin errors++; $display("FAIL fill_full[%0d] got %b exp %b", i, a_full, (i == 15)); end
    end
    din = 4'h7;
    tick();
    wren = 1'b0;
    checks++; if (a_ovf !== 1'b1) begin errors++; $display("FAIL fill_overflow got %b exp 1", a_ovf); end
    checks++; if (a_cnt !== 5'd16) begin errors++; $display("FAIL fill_ovf_count got %0d exp 16", a_cnt); end
    checks++; if (a_hw !== 5'd16) begin errors++; $display("FAIL fill_hw got %0d exp 16", a_hw); end
    tick();
    checks++; if (a_ovf !== 1'b0) begin errors++; $display("FAIL fill_ovf_pulse got %b exp 0", a_ovf); end
  endtask

  task automatic test_drain();
    for (int i = 0; i < 16; i++) begin
      rden = 1'b1;
      tick();
      rden = 1'b0;
      checks++; if ({a_dv, a_dout} !== {1'b1, 4'(i)}) begin errors++; $display("FAIL drain_read[%0d] got %b/%0h exp 1/%0h", i, a_dv, a_dout, i); end
      tick();
      checks++; if ({a_dv, a_dout} !== {1'b0, 4'(i)}) begin errors++; $display("FAIL drain_hold[%0d] got %b/%0h exp 0/%0h", i, a_dv, a_dout, i); end
    end
    checks++; if ({a_empty, a_ae, a_cnt} !== {2'b11, 5'd0}) begin errors++; $display("FAIL drain_empty got %b%b/%0d exp 11/0", a_empty, a_ae, a_cnt); end
    rden = 1'b1;
    tick();
    rden = 1'b0;
    checks++; if ({a_udf, a_dv, a_dout} !== {2'b10, 4'hF}) begin errors++; $display("FAIL drain_underflow got %b%b/%0h exp 10/f", a_udf, a_dv, a_dout); end
    tick();
    checks++; if (a_udf !== 1'b0) begin errors++; $display("FAIL drain_udf_pulse got %b exp 0", a_udf); end
  endtask

  task automatic test_fwft();
    wren = 1'b1; din = 4'hA;
    tick();
    wren = 1'b0;
    checks++; if ({b_dv, b_dout} !== {1'b1, 4'hA}) begin errors++; $display("FAIL fwft_show got %b/%0h exp 1/a", b_dv, b_dout); end
    rden = 1'b1;
    tick();
    rden = 1'b0;
    checks++; if ({b_empty, b_dv} !== 2'b10) begin errors++; $display("FAIL fwft_pop got %b exp 10", {b_empty, b_dv}); end
  endtask

  task automatic test_pass_through();
    for (int i = 0; i < 16; i++) begin
      wren = 1'b1; din = 4'(i);
      tick();
    end
    wren = 1'b1; rden = 1'b1; din = 4'h5;
    tick();
    idle();
    checks++; if ({a_full, a_ovf, a_cnt} !== {2'b10, 5'd16}) begin errors++; $display("FAIL pass_state got %b%b/%0d exp 10/16", a_full, a_ovf, a_cnt); end
    checks++; if ({a_dv, a_dout} !== {1'b1, 4'h0}) begin errors++; $display("FAIL pass_dout got %b/%0h exp 1/0", a_dv, a_dout); end
    for (int k = 1; k <= 16; k++) begin
      rden = 1'b1;
      tick();
      rden = 1'b0;
      checks++; if (a_dout !== ((k < 16) ? 4'(k) : 4'h5)) begin errors++; $display("FAIL pass_read[%0d] got %0h exp %0h", k, a_dout, (k < 16) ? 4'(k) : 4'h5); end
    end
    checks++; if (a_empty !== 1'b1) begin errors++; $display("FAIL pass_empty got %b exp 1", a_empty); end
  endtask

  task automatic test_empty_simul();
    wren = 1'b1; rden = 1'b1; din = 4'h3;
    tick();
    idle();
    checks++; if ({a_cnt, a_udf, a_dv} !== {5'd1, 2'b10}) begin errors++; $display("FAIL esim got %0d/%b%b exp 1/10", a_cnt, a_udf, a_dv); end
    tick();
    checks++; if (a_udf !== 1'b0) begin errors++; $display("FAIL esim_pulse got %b exp 0", a_udf); end
  endtask

  task automatic test_flush_reset();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    checks++; if ({a_cnt, a_hw, a_empty} !== {5'd0, 5'd0, 1'b1}) begin errors++; $display("FAIL flush_clear got %0d/%0d/%b exp 0/0/1", a_cnt, a_hw, a_empty); end
    for (int i = 0; i < 9; i++) begin wren = 1'b1; din = 4'(i + 1); tick(); end
    wren = 1'b0;
    checks++; if ({a_cnt, a_hw} !== {5'd9, 5'd9}) begin errors++; $display("FAIL flush_pre got %0d/%0d exp 9/9", a_cnt, a_hw); end
    flush = 1'b1; wren = 1'b1; rden = 1'b1;
    tick();
    idle();
    checks++; if ({a_cnt, a_hw} !== 10'd0) begin errors++; $display("FAIL flush_count got %0d/%0d exp 0/0", a_cnt, a_hw); end
    checks++; if ({a_empty, a_full, a_ovf, a_udf, a_dv} !== 5'b10000) begin errors++; $display("FAIL flush_flags got %b exp 10000", {a_empty, a_full, a_ovf, a_udf, a_dv}); end
    checks++; if (a_dout !== 4'h5) begin errors++; $display("FAIL flush_dout_hold got %0h exp 5", a_dout); end
    checks++; if (b_dv !== 1'b0) begin errors++; $display("FAIL flush_fwft_dv got %b exp 0", b_dv); end
    for (int i = 0; i < 9; i++) begin wren = 1'b1; din = 4'(i + 2); tick(); end
    rst = 1'b1; flush = 1'b1; wren = 1'b1; rden = 1'b1;
    tick();
    idle();
    checks++; if ({a_cnt, a_hw} !== 10'd0) begin errors++; $display("FAIL rst_count got %0d/%0d exp 0/0", a_cnt, a_hw); end
    checks++; if ({a_empty, a_full, a_ae, a_af, a_dv, a_ovf, a_udf} !== 7'b1010000) begin errors++; $display("FAIL rst_flags got %b exp 1010000", {a_empty, a_full, a_ae, a_af, a_dv, a_ovf, a_udf}); end
    checks++; if (a_dout !== 4'h0) begin errors++; $display("FAIL rst_dout got %0h exp 0", a_dout); end
    for (int i = 0; i < 40; i++) begin
      wren = 1'b1; rden = (i > 0); din = 4'(i * 7 + 3);
      tick();
      checks++; if ({b_dv, b_dout} !== {1'b1, 4'(i * 7 + 3)}) begin errors++; $display("FAIL wrap_head[%0d] got %b/%0h exp 1/%0h", i, b_dv, b_dout, 4'(i * 7 + 3)); end
      checks++; if (a_cnt !== 5'd1) begin errors++; $display("FAIL wrap_count[%0d] got %0d exp 1", i, a_cnt); end
      if (i > 0) begin
        checks++; if (a_dout !== 4'((i - 1) * 7 + 3)) begin errors++; $display("FAIL wrap_read[%0d] got %0h exp %0h", i, a_dout, 4'((i - 1) * 7 + 3)); end
      end
    end
    idle();
    tick();
  endtask

  initial begin
    test_reset();
    test_fill();
    test_drain();
    test_fwft();
    test_pass_through();
    test_empty_simul();
    test_flush_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sync_fifo_ext.md
SYNC_FIFO_EXT -- requirements
Module: sync_fifo_ext

Interface
REQ-001 SHALL have parameter WIDTH, default 4, data width in bits (>=1).
REQ-002 SHALL have parameter DEPTH, default 16, entry count; power of two, >=2.
REQ-003 SHALL have parameter FWFT, default 0; 0 = registered-read mode, 1 = first-word-fall-through mode.
REQ-004 SHALL have parameter ALMOST_FULL_DEPTH, default 14, almost_full threshold (1..DEPTH).
REQ-005 SHALL have parameter ALMOST_EMPTY_DEPTH, default 2, almost_empty threshold (0..DEPTH-1).
REQ-006 SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-007 SHALL have port rst, input, 1; reset is synchronous and active-high.
REQ-008 SHALL have port flush, input, 1, synchronous content discard.
REQ-009 SHALL have port wren, input, 1, write request.
REQ-010 SHALL have port din, input, WIDTH, write data.
REQ-011 SHALL have port rden, input, 1, read request (FWFT=1: pop/acknowledge).
REQ-012 SHALL have port dout, output, WIDTH, read data.
REQ-013 SHALL have port dout_valid, output, 1, dout qualifier.
REQ-014 SHALL have ports full, empty, almost_full, almost_empty, output, 1 each, status flags.
REQ-015 SHALL have port fifo_counter, output, CLOG2(DEPTH)+1, stored-entry count.
REQ-016 SHALL have port high_water, output, CLOG2(DEPTH)+1, maximum fifo_counter since last reset/flush.
REQ-017 SHALL have ports overflow, underflow, output, 1 each, one-cycle error pulses.

Function
REQ-018 SHALL accept a write (wr_acc) when wren && !flush && (!full || rd_acc).
REQ-019 SHALL accept a read (rd_acc) when rden && !flush && !empty; a read is never accepted from an empty FIFO, even with a simultaneous write.
REQ-020 SHALL store din at wr_ptr on wr_acc, advancing wr_ptr modulo DEPTH; SHALL advance rd_ptr modulo DEPTH on rd_acc.
REQ-021 SHALL update fifo_counter next cycle: +1 on wr_acc only, -1 on rd_acc only, unchanged on both or neither.
REQ-022 SHALL register full = (count==DEPTH) and empty = (count==0), consistent with fifo_counter every cycle.
REQ-023 SHALL drive almost_full = (fifo_counter >= ALMOST_FULL_DEPTH) and almost_empty = (fifo_counter <= ALMOST_EMPTY_DEPTH).
REQ-024 SHALL, when full, accept a simultaneous write and read (pass-through); count stays DEPTH; overflow not raised.
REQ-025 SHALL pulse overflow for one cycle, the cycle after wren && !flush is rejected; no state change.
REQ-026 SHALL pulse underflow for one cycle, the cycle after rden && !flush && empty; no state change.
REQ-027 FWFT=0: SHALL register dout <= mem[rd_ptr] on rd_acc, dout_valid high exactly the next cycle; otherwise dout holds, dout_valid low.
REQ-028 FWFT=1: SHALL drive dout = mem[rd_ptr] and dout_valid = !empty; a written word appears on dout one cycle after its write edge when FIFO was empty.
REQ-029 SHALL update high_water <= max(high_water, next fifo_counter) each cycle.
REQ-030 flush SHALL, next cycle, zero pointers, fifo_counter, high_water; set empty=1, full=0; dout_valid=0; FWFT=0 dout holds; wren/rden that cycle ignored, no error pulses.
REQ-031 Memory contents SHALL NOT require reset.

Reset
REQ-032 rst SHALL override flush, wren, rden.
REQ-033 After rst: fifo_counter=0, high_water=0, empty=1, full=0, almost_empty=1, almost_full=0, dout=0, dout_valid=0, overflow=0, underflow=0, pointers=0.
REQ-034 rst asserted mid-operation SHALL discard all contents in one cycle; first accepted write after release lands at address 0.

Verification
REQ-035 Fill: DEPTH=16, 16 writes 0x0..0xF -> full=1, count=16, almost_full from count 14, high_water=16; 17th write -> overflow pulse, count 16.
REQ-036 Drain FWFT=0: 16 reads -> dout 0x0..0xF each one cycle after rden, dout_valid one-cycle pulses; extra read -> underflow pulse, dout holds 0xF.
REQ-037 FWFT=1: write 0xA to empty -> next cycle dout=0xA, dout_valid=1; rden -> following cycle empty=1, dout_valid=0.
REQ-038 Full pass-through: full, wren+rden with din=0x5 -> count stays 16, no overflow, 0x5 read out 16th after.
REQ-039 Empty simultaneous: empty, wren+rden -> count=1, underflow pulse, no dout_valid.
REQ-040 Flush/reset mid-stream: count=9, flush with wren+rden -> count=0, high_water=0, no pulses; repeat with rst -> reset values of REQ-033, pointer wrap verified over 40 writes.
